// File: rtl/accelerator_state_vector_input_pkg.sv
// Shared types and constants for the state-space accelerator input-vector stage.
package accelerator_state_pkg;

    typedef enum logic [2:0] {
        STARTER = 3'd0,
        LOAD_Y  = 3'd1,
        LOAD_R  = 3'd2,
        LOAD_K  = 3'd3,
        OUTPUT  = 3'd4,
        ENDER   = 3'd5
    } state_t;

    localparam int unsigned PKG_DATA_SIZE = 64;

    localparam logic [PKG_DATA_SIZE-1:0] ZERO_DATA = 64'd0;
    localparam logic [PKG_DATA_SIZE-1:0] ONE_DATA  = 64'd1;

    // Pulse levels for the one-cycle strobes driven by this stage.
    localparam logic FULL  = 1'b1;
    localparam logic EMPTY = 1'b0;

endpackage

// File: rtl/accelerator_vector_buffer.sv
// Register file holding the y vector: synchronous write, combinational read,
// asynchronous active-low clear.
module accelerator_vector_buffer #(
    parameter  int DATA_SIZE = 64,
    parameter  int MAX_SIZE  = 16,
    localparam int AW        = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    logic [DATA_SIZE-1:0] mem_q [MAX_SIZE];

    // Storage array: cleared on reset, one entry written per strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_SIZE; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/accelerator_state_vector_input.sv
// Computes u(k) = r(k) - K*y(k): y is buffered once, K streams row-major and
// r arrives once per row; one u element is emitted per row.
module accelerator_state_vector_input
    import accelerator_state_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int MAX_SIZE     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 DATA_K_IN_I_ENABLE,
    input  logic                 DATA_K_IN_J_ENABLE,
    input  logic                 DATA_Y_IN_ENABLE,
    input  logic                 DATA_R_IN_ENABLE,
    output logic                 DATA_U_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_K_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_K_J_IN,
    input  logic [DATA_SIZE-1:0] DATA_K_IN,
    input  logic [DATA_SIZE-1:0] DATA_Y_IN,
    input  logic [DATA_SIZE-1:0] DATA_R_IN,
    output logic [DATA_SIZE-1:0] DATA_U_OUT
);

    localparam int AW    = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    localparam int IDX_W = $clog2(MAX_SIZE + 1);

    // The control word is carried only for interface compatibility with sibling stages.
    if (CONTROL_SIZE < 1) begin : g_control_size_unused
    end

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] rows_q, rows_d;
    logic [IDX_W-1:0]     cols_q, cols_d;
    logic [DATA_SIZE-1:0] i_q, i_d;
    logic [IDX_W-1:0]     j_q, j_d;
    logic [DATA_SIZE-1:0] r_q, r_d;
    logic [DATA_SIZE-1:0] acc_q, acc_d;
    logic [DATA_SIZE-1:0] u_q, u_d;
    logic                 u_en_q, u_en_d;
    logic                 ready_q, ready_d;

    logic                 y_wr_s;
    logic [DATA_SIZE-1:0] y_rd_s;
    logic [DATA_SIZE-1:0] prod_s;
    logic [IDX_W-1:0]     cols_sat_s;
    logic                 last_col_s;
    logic                 row_mark_s;
    logic                 k_take_s;

    accelerator_vector_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .MAX_SIZE  (MAX_SIZE)
    ) u_y_buf (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (y_wr_s),
        .wr_addr (j_q[AW-1:0]),
        .wr_data (DATA_Y_IN),
        .rd_addr (j_q[AW-1:0]),
        .rd_data (y_rd_s)
    );

    assign cols_sat_s = (SIZE_K_J_IN > DATA_SIZE'(MAX_SIZE)) ? IDX_W'(MAX_SIZE)
                                                             : SIZE_K_J_IN[IDX_W-1:0];
    assign last_col_s = (j_q == (cols_q - IDX_W'(1)));
    assign prod_s     = DATA_K_IN * y_rd_s;

    // Rows are framed by the column count, so an element is taken with or
    // without its row-start mark.
    assign row_mark_s = DATA_K_IN_I_ENABLE & (j_q == IDX_W'(0));
    assign k_take_s   = DATA_K_IN_J_ENABLE | (DATA_K_IN_J_ENABLE & row_mark_s);

    // Next-state, counter, accumulator and output computation.
    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        i_d     = i_q;
        j_d     = j_q;
        r_d     = r_q;
        acc_d   = acc_q;
        u_d     = u_q;
        u_en_d  = EMPTY;
        ready_d = EMPTY;
        y_wr_s  = EMPTY;
        case (state_q)
            STARTER: begin
                if (START) begin
                    rows_d = SIZE_K_I_IN;
                    cols_d = cols_sat_s;
                    i_d    = DATA_SIZE'(ZERO_DATA);
                    j_d    = IDX_W'(0);
                    if ((SIZE_K_I_IN == DATA_SIZE'(ZERO_DATA)) || (cols_sat_s == IDX_W'(0))) begin
                        state_d = ENDER;
                    end else begin
                        state_d = LOAD_Y;
                    end
                end else begin
                    state_d = STARTER;
                end
            end
            LOAD_Y: begin
                if (DATA_Y_IN_ENABLE) begin
                    y_wr_s = FULL;
                    if (last_col_s) begin
                        j_d     = IDX_W'(0);
                        state_d = LOAD_R;
                    end else begin
                        j_d = j_q + IDX_W'(1);
                    end
                end else begin
                    y_wr_s = EMPTY;
                end
            end
            LOAD_R: begin
                if (DATA_R_IN_ENABLE) begin
                    r_d     = DATA_R_IN;
                    acc_d   = DATA_SIZE'(ZERO_DATA);
                    j_d     = IDX_W'(0);
                    state_d = LOAD_K;
                end else begin
                    state_d = LOAD_R;
                end
            end
            LOAD_K: begin
                if (k_take_s) begin
                    acc_d = acc_q + prod_s;
                    if (last_col_s) begin
                        j_d     = IDX_W'(0);
                        state_d = OUTPUT;
                    end else begin
                        j_d = j_q + IDX_W'(1);
                    end
                end else begin
                    state_d = LOAD_K;
                end
            end
            OUTPUT: begin
                u_d    = r_q - acc_q;
                u_en_d = FULL;
                i_d    = i_q + DATA_SIZE'(ONE_DATA);
                if ((i_q + DATA_SIZE'(ONE_DATA)) == rows_q) begin
                    state_d = ENDER;
                end else begin
                    j_d     = IDX_W'(0);
                    state_d = LOAD_R;
                end
            end
            ENDER: begin
                ready_d = FULL;
                state_d = STARTER;
            end
            default: begin
                state_d = STARTER;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= STARTER;
            rows_q  <= '0;
            cols_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            u_q     <= '0;
            u_en_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            i_q     <= i_d;
            j_q     <= j_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            u_q     <= u_d;
            u_en_q  <= u_en_d;
            ready_q <= ready_d;
        end
    end

    assign DATA_U_OUT        = u_q;
    assign DATA_U_OUT_ENABLE = u_en_q;
    assign READY             = ready_q;

endmodule

// File: tb/tb_accelerator_state_vector_input.sv
// Directed self-checking bench for accelerator_state_vector_input.
module tb_accelerator_state_vector_input;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic        k_i_en, k_j_en, y_en, r_en;
    logic        u_en;
    logic [63:0] size_i, size_j, k_in, y_in, r_in, u_out;

    int          n_cmp;
    int          n_bad;
    int          u_cnt;
    int          rdy_cnt;
    logic [63:0] u_last;

    accelerator_state_vector_input dut (
        .CLK                (clk),
        .RST                (rst_n),
        .START              (start),
        .READY              (ready),
        .DATA_K_IN_I_ENABLE (k_i_en),
        .DATA_K_IN_J_ENABLE (k_j_en),
        .DATA_Y_IN_ENABLE   (y_en),
        .DATA_R_IN_ENABLE   (r_en),
        .DATA_U_OUT_ENABLE  (u_en),
        .SIZE_K_I_IN        (size_i),
        .SIZE_K_J_IN        (size_j),
        .DATA_K_IN          (k_in),
        .DATA_Y_IN          (y_in),
        .DATA_R_IN          (r_in),
        .DATA_U_OUT         (u_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (u_en) begin
            u_cnt  <= u_cnt + 1;
            u_last <= u_out;
        end
        if (ready) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [63:0] rows, input logic [63:0] cols);
        size_i = rows; size_j = cols; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_y(input logic [63:0] v);
        y_en = 1'b1; y_in = v;
        tick();
        y_en = 1'b0;
    endtask

    task automatic drive_r(input logic [63:0] v);
        r_en = 1'b1; r_in = v;
        tick();
        r_en = 1'b0;
    endtask

    task automatic drive_k(input logic [63:0] v, input logic first);
        k_j_en = 1'b1; k_i_en = first; k_in = v;
        tick();
        k_j_en = 1'b0; k_i_en = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (u_en !== 1'b0) begin n_bad++; $display("FAIL reset_u_en: got %0b want 0", u_en); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %0b want 0", ready); end
        n_cmp++; if (u_out !== 64'd0) begin n_bad++; $display("FAIL reset_u: got %0d want 0", u_out); end
    endtask

    task automatic test_basic_2x2();
        int u0, r0;
        u0 = u_cnt; r0 = rdy_cnt;
        start_op(64'd2, 64'd2);
        drive_y(64'd5); drive_y(64'd6);
        drive_r(64'd100);
        drive_k(64'd1, 1'b1); drive_k(64'd2, 1'b0);
        n_cmp++; if (u_en !== 1'b0) begin n_bad++; $display("FAIL basic_row0_early: got %0b want 0", u_en); end
        tick();
        n_cmp++; if (u_en !== 1'b1) begin n_bad++; $display("FAIL basic_row0_en: got %0b want 1", u_en); end
        n_cmp++; if (u_out !== 64'd83) begin n_bad++; $display("FAIL basic_row0_u: got %0d want 83", u_out); end
        drive_r(64'd200);
        drive_k(64'd3, 1'b1); drive_k(64'd4, 1'b0);
        n_cmp++; if (u_en !== 1'b0) begin n_bad++; $display("FAIL basic_row1_early: got %0b want 0", u_en); end
        tick();
        n_cmp++; if (u_en !== 1'b1) begin n_bad++; $display("FAIL basic_row1_en: got %0b want 1", u_en); end
        n_cmp++; if (u_out !== 64'd161) begin n_bad++; $display("FAIL basic_row1_u: got %0d want 161", u_out); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_early: got %0b want 0", ready); end
        tick();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %0b want 1", ready); end
        n_cmp++; if (u_en !== 1'b0) begin n_bad++; $display("FAIL basic_u_en_drop: got %0b want 0", u_en); end
        n_cmp++; if (u_out !== 64'd161) begin n_bad++; $display("FAIL basic_u_hold: got %0d want 161", u_out); end
        tick();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_drop: got %0b want 0", ready); end
        n_cmp++; if (u_cnt - u0 !== 2) begin n_bad++; $display("FAIL basic_u_pulses: got %0d want 2", u_cnt - u0); end
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_bad++; $display("FAIL basic_ready_pulses: got %0d want 1", rdy_cnt - r0); end
    endtask

    task automatic test_signed();
        start_op(64'd1, 64'd1);
        drive_y(64'd7);
        drive_r(64'd0);
        drive_k(64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        tick();
        n_cmp++; if (u_en !== 1'b1) begin n_bad++; $display("FAIL signed_en: got %0b want 1", u_en); end
        n_cmp++; if (u_out !== 64'd21) begin n_bad++; $display("FAIL signed_u: got %0d want 21", u_out); end
        tick();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL signed_ready: got %0b want 1", ready); end
        tick();
    endtask

    task automatic test_zero_size();
        int u0, r0;
        u0 = u_cnt; r0 = rdy_cnt;
        start_op(64'd0, 64'd3);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL zero_ready_early: got %0b want 0", ready); end
        tick();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %0b want 1", ready); end
        tick();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL zero_ready_drop: got %0b want 0", ready); end
        start_op(64'd2, 64'd0);
        tick();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL zero_cols_ready: got %0b want 1", ready); end
        tick(); tick();
        n_cmp++; if (u_cnt - u0 !== 0) begin n_bad++; $display("FAIL zero_u_pulses: got %0d want 0", u_cnt - u0); end
        n_cmp++; if (rdy_cnt - r0 !== 2) begin n_bad++; $display("FAIL zero_ready_pulses: got %0d want 2", rdy_cnt - r0); end
    endtask

    task automatic test_saturate();
        int u0, r0;
        u0 = u_cnt; r0 = rdy_cnt;
        start_op(64'd1, 64'd21);
        for (int k = 0; k < 21; k++) drive_y((k < 16) ? 64'(k + 1) : 64'd100);
        drive_r(64'd1000);
        for (int k = 0; k < 21; k++) drive_k(64'd1, (k == 0));
        tick(); tick(); tick();
        n_cmp++; if (u_cnt - u0 !== 1) begin n_bad++; $display("FAIL sat_u_pulses: got %0d want 1", u_cnt - u0); end
        n_cmp++; if (u_last !== 64'd864) begin n_bad++; $display("FAIL sat_u: got %0d want 864", u_last); end
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_bad++; $display("FAIL sat_ready_pulses: got %0d want 1", rdy_cnt - r0); end
        n_cmp++; if (u_out !== 64'd864) begin n_bad++; $display("FAIL sat_u_hold: got %0d want 864", u_out); end
    endtask

    task automatic test_k_with_r();
        start_op(64'd1, 64'd2);
        drive_y(64'd2); drive_y(64'd3);
        r_en = 1'b1; r_in = 64'd50; k_j_en = 1'b1; k_i_en = 1'b1; k_in = 64'd9;
        tick();
        r_en = 1'b0; k_j_en = 1'b0; k_i_en = 1'b0;
        drive_k(64'd1, 1'b1); drive_k(64'd1, 1'b0);
        tick();
        n_cmp++; if (u_en !== 1'b1) begin n_bad++; $display("FAIL kr_en: got %0b want 1", u_en); end
        n_cmp++; if (u_out !== 64'd45) begin n_bad++; $display("FAIL kr_u: got %0d want 45", u_out); end
        tick(); tick();
    endtask

    task automatic test_start_in_load_k();
        int u0, r0;
        u0 = u_cnt; r0 = rdy_cnt;
        start_op(64'd1, 64'd2);
        drive_y(64'd4); drive_y(64'd5);
        drive_r(64'd10);
        size_i = 64'd5; size_j = 64'd1; start = 1'b1;
        drive_k(64'd2, 1'b1); drive_k(64'd3, 1'b0);
        start = 1'b0;
        tick();
        n_cmp++; if (u_out !== 64'hFFFF_FFFF_FFFF_FFF3) begin n_bad++; $display("FAIL start_k_u: got %0h want fffffffffffffff3", u_out); end
        tick(); tick(); tick();
        n_cmp++; if (u_cnt - u0 !== 1) begin n_bad++; $display("FAIL start_k_u_pulses: got %0d want 1", u_cnt - u0); end
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_bad++; $display("FAIL start_k_ready_pulses: got %0d want 1", rdy_cnt - r0); end
    endtask

    task automatic test_reset_mid();
        int u0, r0;
        u0 = u_cnt; r0 = rdy_cnt;
        start_op(64'd2, 64'd2);
        drive_y(64'd5); drive_y(64'd6);
        drive_r(64'd100);
        drive_k(64'd1, 1'b1); drive_k(64'd2, 1'b0);
        tick();
        drive_r(64'd200);
        drive_k(64'd3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (u_en !== 1'b0) begin n_bad++; $display("FAIL abort_u_en: got %0b want 0", u_en); end
        n_cmp++; if (u_out !== 64'd0) begin n_bad++; $display("FAIL abort_u: got %0d want 0", u_out); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %0b want 0", ready); end
        tick(); tick();
        rst_n = 1'b1;
        drive_k(64'd4, 1'b0);
        tick(); tick(); tick();
        n_cmp++; if (u_cnt - u0 !== 1) begin n_bad++; $display("FAIL abort_u_pulses: got %0d want 1", u_cnt - u0); end
        n_cmp++; if (rdy_cnt - r0 !== 0) begin n_bad++; $display("FAIL abort_ready_pulses: got %0d want 0", rdy_cnt - r0); end
        u0 = u_cnt; r0 = rdy_cnt;
        start_op(64'd2, 64'd2);
        drive_y(64'd5); drive_y(64'd6);
        drive_r(64'd100);
        drive_k(64'd1, 1'b1); drive_k(64'd2, 1'b0);
        tick();
        n_cmp++; if (u_out !== 64'd83) begin n_bad++; $display("FAIL rerun_row0_u: got %0d want 83", u_out); end
        drive_r(64'd200);
        drive_k(64'd3, 1'b1); drive_k(64'd4, 1'b0);
        tick();
        n_cmp++; if (u_out !== 64'd161) begin n_bad++; $display("FAIL rerun_row1_u: got %0d want 161", u_out); end
        tick(); tick();
        n_cmp++; if (u_cnt - u0 !== 2) begin n_bad++; $display("FAIL rerun_u_pulses: got %0d want 2", u_cnt - u0); end
        n_cmp++; if (rdy_cnt - r0 !== 1) begin n_bad++; $display("FAIL rerun_ready_pulses: got %0d want 1", rdy_cnt - r0); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        u_cnt = 0; rdy_cnt = 0; u_last = 64'd0;
        rst_n = 1'b0; start = 1'b0;
        k_i_en = 1'b0; k_j_en = 1'b0; y_en = 1'b0; r_en = 1'b0;
        size_i = 64'd0; size_j = 64'd0; k_in = 64'd0; y_in = 64'd0; r_in = 64'd0;
        tick(); tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic_2x2();
        test_signed();
        test_zero_size();
        test_saturate();
        test_k_with_r();
        test_start_in_load_k();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
